// File: rtl/bus_load_bank_if.sv
// rtl/bus_load_bank_if.sv - common-bus destination signals: register strobes, register readback, memory-write handshake
interface bus_load_bank_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] bus_data;
    logic              ld_ar, inr_ar, clr_ar;
    logic              ld_pc, inr_pc, clr_pc;
    logic              ld_dr, inr_dr, clr_dr;
    logic              ld_ac, inr_ac, clr_ac;
    logic              ld_ir;
    logic              ld_tr, inr_tr, clr_tr;
    logic              mem_wr_req;
    logic              mem_wr_ack;

    logic [ADDR_W-1:0] ar_outdata;
    logic [ADDR_W-1:0] pc_outdata;
    logic [DATA_W-1:0] dr_outdata;
    logic [DATA_W-1:0] ac_outdata;
    logic [DATA_W-1:0] ir_outdata;
    logic [DATA_W-1:0] tr_outdata;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_done;
    logic              busy;
    logic              err_conflict;

    modport slave (
        input  bus_data,
        input  ld_ar, inr_ar, clr_ar,
        input  ld_pc, inr_pc, clr_pc,
        input  ld_dr, inr_dr, clr_dr,
        input  ld_ac, inr_ac, clr_ac,
        input  ld_ir,
        input  ld_tr, inr_tr, clr_tr,
        input  mem_wr_req, mem_wr_ack,
        output ar_outdata, pc_outdata, dr_outdata, ac_outdata, ir_outdata, tr_outdata,
        output mem_write, mem_addr, mem_wdata, wr_done, busy, err_conflict
    );

    modport master (
        output bus_data,
        output ld_ar, inr_ar, clr_ar,
        output ld_pc, inr_pc, clr_pc,
        output ld_dr, inr_dr, clr_dr,
        output ld_ac, inr_ac, clr_ac,
        output ld_ir,
        output ld_tr, inr_tr, clr_tr,
        output mem_wr_req, mem_wr_ack,
        input  ar_outdata, pc_outdata, dr_outdata, ac_outdata, ir_outdata, tr_outdata,
        input  mem_write, mem_addr, mem_wdata, wr_done, busy, err_conflict
    );
endinterface

// File: rtl/bus_load_bank.sv
// rtl/bus_load_bank.sv - AR/PC/DR/AC/IR/TR bus destination registers plus single-outstanding memory-write engine
// Optional control-conflict checker enabled by defining BUS_CONFLICT_CHECK_EN.
module bus_load_bank #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic            CLK,
    input  logic            RST,
    bus_load_bank_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } wr_state_e;

    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] tr_q, tr_d;

    wr_state_e         state_q, state_d;
    logic              capture;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Each register resolves its own strobes: clr > ld > inr > hold.
    always_comb begin
        ar_d = ar_q;
        if (bus.clr_ar)      ar_d = '0;
        else if (bus.ld_ar)  ar_d = bus.bus_data[ADDR_W-1:0];
        else if (bus.inr_ar) ar_d = ar_q + ADDR_W'(1);

        pc_d = pc_q;
        if (bus.clr_pc)      pc_d = '0;
        else if (bus.ld_pc)  pc_d = bus.bus_data[ADDR_W-1:0];
        else if (bus.inr_pc) pc_d = pc_q + ADDR_W'(1);

        dr_d = dr_q;
        if (bus.clr_dr)      dr_d = '0;
        else if (bus.ld_dr)  dr_d = bus.bus_data;
        else if (bus.inr_dr) dr_d = dr_q + DATA_W'(1);

        ac_d = ac_q;
        if (bus.clr_ac)      ac_d = '0;
        else if (bus.ld_ac)  ac_d = bus.bus_data;
        else if (bus.inr_ac) ac_d = ac_q + DATA_W'(1);

        ir_d = ir_q;
        if (bus.ld_ir)       ir_d = bus.bus_data;

        tr_d = tr_q;
        if (bus.clr_tr)      tr_d = '0;
        else if (bus.ld_tr)  tr_d = bus.bus_data;
        else if (bus.inr_tr) tr_d = tr_q + DATA_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
        end
    end

    // Requests are only accepted in IDLE; ack only counts once WAIT is reached.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_wr_req) begin
                    state_d = S_WAIT;
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_wr_ack) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address is the AR value before this edge, so a same-cycle ld_ar does not leak in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                mem_addr_q  <= ar_q;
                mem_wdata_q <= bus.bus_data;
            end
        end
    end

    assign bus.ar_outdata = ar_q;
    assign bus.pc_outdata = pc_q;
    assign bus.dr_outdata = dr_q;
    assign bus.ac_outdata = ac_q;
    assign bus.ir_outdata = ir_q;
    assign bus.tr_outdata = tr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_write  = (state_q == S_WAIT);
    assign bus.wr_done    = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);

`ifdef BUS_CONFLICT_CHECK_EN
    logic err_q;
    logic conflict_now;

    function automatic logic multi_hot(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_comb begin
        conflict_now = multi_hot(bus.ld_ar, bus.inr_ar, bus.clr_ar)
                     | multi_hot(bus.ld_pc, bus.inr_pc, bus.clr_pc)
                     | multi_hot(bus.ld_dr, bus.inr_dr, bus.clr_dr)
                     | multi_hot(bus.ld_ac, bus.inr_ac, bus.clr_ac)
                     | multi_hot(bus.ld_tr, bus.inr_tr, bus.clr_tr)
                     | (bus.mem_wr_req & bus.busy);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= err_q | conflict_now;
    end

    assign bus.err_conflict = err_q;
`else
    assign bus.err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_bus_load_bank.sv
// tb/tb_bus_load_bank.sv - scoreboard bench for bus_load_bank: directed stimulus, decoupled monitor
module tb_bus_load_bank;
    logic CLK;
    logic RST;

    bus_load_bank_if #(.ADDR_W(12), .DATA_W(16)) bif ();

    bus_load_bank #(.ADDR_W(12), .DATA_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif)
    );

`ifdef BUS_CONFLICT_CHECK_EN
    localparam logic [31:0] CONF = 32'd1;
`else
    localparam logic [31:0] CONF = 32'd0;
`endif

    localparam int S_AR = 0, S_PC = 1, S_DR = 2, S_AC = 3, S_IR = 4, S_TR = 5;
    localparam int S_MW = 6, S_BUSY = 7, S_MADDR = 8, S_MDATA = 9, S_DONE = 10, S_ERR = 11;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          mw_cycles;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mw_cnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic ex(input int dly, input int sel, input logic [31:0] val, input string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.val  = val;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_AR:    pick = {20'd0, bif.ar_outdata};
            S_PC:    pick = {20'd0, bif.pc_outdata};
            S_DR:    pick = {16'd0, bif.dr_outdata};
            S_AC:    pick = {16'd0, bif.ac_outdata};
            S_IR:    pick = {16'd0, bif.ir_outdata};
            S_TR:    pick = {16'd0, bif.tr_outdata};
            S_MW:    pick = {31'd0, bif.mem_write};
            S_BUSY:  pick = {31'd0, bif.busy};
            S_MADDR: pick = {20'd0, bif.mem_addr};
            S_MDATA: pick = {16'd0, bif.mem_wdata};
            S_DONE:  pick = {31'd0, bif.wr_done};
            default: pick = {31'd0, bif.err_conflict};
        endcase
    endfunction

    task automatic clr_ctrl();
        bif.ld_ar = 0; bif.inr_ar = 0; bif.clr_ar = 0;
        bif.ld_pc = 0; bif.inr_pc = 0; bif.clr_pc = 0;
        bif.ld_dr = 0; bif.inr_dr = 0; bif.clr_dr = 0;
        bif.ld_ac = 0; bif.inr_ac = 0; bif.clr_ac = 0;
        bif.ld_ir = 0;
        bif.ld_tr = 0; bif.inr_tr = 0; bif.clr_tr = 0;
        bif.mem_wr_req = 0;
        bif.mem_wr_ack = 0;
    endtask

    // Monitor: samples mid-low-phase, drains due expectations, and scores each completed write.
    initial begin
        forever begin
            exp_t keep[$];
            @(negedge CLK);
            #3;
            keep.delete();
            foreach (exp_q[i]) begin
                if (exp_q[i].cyc <= cyc) chk(exp_q[i].name, pick(exp_q[i].sel), exp_q[i].val);
                else keep.push_back(exp_q[i]);
            end
            exp_q = keep;
            if (RST) mw_cnt = 0;
            else if (bif.mem_write) mw_cnt++;
            if (bif.wr_done) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr_done", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", {20'd0, bif.mem_addr}, {20'd0, w.addr});
                    chk("wr_data", {16'd0, bif.mem_wdata}, {16'd0, w.data});
                    chk("wr_mem_write_cycles", mw_cnt, w.mw_cycles);
                end
                mw_cnt = 0;
            end
        end
    end

    initial begin
        RST = 1'b1;
        bif.bus_data = '0;
        clr_ctrl();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int s = S_AR; s <= S_BUSY; s++) ex(0, s, 32'd0, "reset_state");
        ex(0, S_MADDR, 32'd0, "reset_mem_addr");
        ex(0, S_ERR, 32'd0, "reset_err");
        @(negedge CLK);

        bif.bus_data = 16'hA123; bif.ld_ar = 1; bif.ld_ac = 1;
        ex(1, S_AR, 32'h123, "ar_load_low_bits");
        ex(1, S_AC, 32'hA123, "ac_load");
        @(negedge CLK); clr_ctrl(); bif.inr_ar = 1;
        ex(1, S_AR, 32'h124, "ar_inc1");
        ex(2, S_AR, 32'h125, "ar_inc2");
        @(negedge CLK); @(negedge CLK); clr_ctrl();

        bif.bus_data = 16'h0FFF; bif.ld_pc = 1;
        ex(1, S_PC, 32'hFFF, "pc_load");
        @(negedge CLK); clr_ctrl(); bif.inr_pc = 1;
        ex(1, S_PC, 32'h000, "pc_wrap");
        @(negedge CLK); clr_ctrl();

        bif.bus_data = 16'hFFFF; bif.ld_tr = 1;
        ex(1, S_TR, 32'hFFFF, "tr_load");
        @(negedge CLK); clr_ctrl(); bif.inr_tr = 1;
        ex(1, S_TR, 32'h0000, "tr_wrap");
        @(negedge CLK); clr_ctrl();

        bif.bus_data = 16'h1234; bif.ld_dr = 1;
        ex(1, S_DR, 32'h1234, "dr_load");
        @(negedge CLK); clr_ctrl(); bif.bus_data = 16'h0042; bif.ld_dr = 1; bif.inr_dr = 1;
        ex(1, S_DR, 32'h0042, "dr_ld_over_inr");
        @(negedge CLK); clr_ctrl(); bif.clr_dr = 1; bif.ld_dr = 1; bif.inr_dr = 1;
        ex(1, S_DR, 32'h0000, "dr_clr_wins");
        ex(1, S_ERR, CONF, "err_after_dr_conflict");
        @(negedge CLK); clr_ctrl();

        bif.bus_data = 16'hBEEF; bif.ld_ir = 1;
        ex(1, S_IR, 32'hBEEF, "ir_load");
        ex(1, S_AC, 32'hA123, "ac_hold");
        @(negedge CLK); clr_ctrl();

        bif.bus_data = 16'h0010; bif.ld_ar = 1;
        ex(1, S_AR, 32'h010, "ar_load_010");
        @(negedge CLK); clr_ctrl();

        // Write with 4-cycle ack delay, same-cycle AR load, stray requests in WAIT and DONE.
        bif.bus_data = 16'h5555; bif.ld_ar = 1; bif.mem_wr_req = 1;
        wr_q.push_back('{12'h010, 16'h5555, 5});
        ex(1, S_AR, 32'h555, "ar_load_with_capture");
        ex(1, S_MW, 32'd1, "mem_write_rise");
        ex(1, S_BUSY, 32'd1, "busy_rise");
        @(negedge CLK); clr_ctrl(); bif.bus_data = 16'h0000;
        @(negedge CLK); bif.mem_wr_req = 1;
        ex(0, S_MADDR, 32'h010, "mem_addr_stable");
        ex(0, S_MDATA, 32'h5555, "mem_wdata_stable");
        @(negedge CLK); bif.mem_wr_req = 0;
        ex(0, S_MW, 32'd1, "mem_write_held");
        @(negedge CLK);
        @(negedge CLK); bif.mem_wr_ack = 1;
        @(negedge CLK); bif.mem_wr_ack = 0; bif.mem_wr_req = 1;
        ex(0, S_DONE, 32'd1, "wr_done_pulse");
        ex(0, S_BUSY, 32'd1, "busy_in_done");
        ex(0, S_MW, 32'd0, "mem_write_drop");
        @(negedge CLK); bif.mem_wr_req = 0;
        ex(0, S_BUSY, 32'd0, "busy_idle");
        ex(0, S_DONE, 32'd0, "wr_done_one_cycle");
        ex(0, S_MW, 32'd0, "no_write_from_done_req");
        @(negedge CLK);

        // Abort by reset while in WAIT; ack alongside the request must not be seen.
        bif.bus_data = 16'h0777; bif.mem_wr_req = 1; bif.mem_wr_ack = 1;
        @(negedge CLK); clr_ctrl();
        ex(0, S_MW, 32'd1, "early_ack_ignored");
        ex(0, S_MADDR, 32'h555, "abort_mem_addr");
        @(negedge CLK); RST = 1'b1;
        ex(0, S_MW, 32'd0, "async_rst_mem_write");
        ex(0, S_BUSY, 32'd0, "async_rst_busy");
        ex(0, S_AR, 32'd0, "async_rst_ar");
        ex(0, S_AC, 32'd0, "async_rst_ac");
        ex(0, S_MADDR, 32'd0, "async_rst_mem_addr");
        ex(0, S_ERR, 32'd0, "async_rst_err");
        @(negedge CLK); RST = 1'b0; bif.mem_wr_ack = 1;
        @(negedge CLK); bif.mem_wr_ack = 0;
        ex(0, S_DONE, 32'd0, "late_ack_no_done");
        ex(0, S_BUSY, 32'd0, "late_ack_idle");
        @(negedge CLK);

        // Minimum-latency write with a second request while busy.
        bif.bus_data = 16'h9ABC; bif.mem_wr_req = 1;
        wr_q.push_back('{12'h000, 16'h9ABC, 2});
        ex(1, S_ERR, 32'd0, "err_clear_idle_req");
        @(negedge CLK); bif.bus_data = 16'h0000;
        @(negedge CLK); bif.mem_wr_req = 0; bif.mem_wr_ack = 1;
        ex(0, S_ERR, CONF, "err_req_while_busy");
        @(negedge CLK); bif.mem_wr_ack = 0;
        ex(0, S_DONE, 32'd1, "wr2_done");
        @(negedge CLK);
        ex(0, S_BUSY, 32'd0, "wr2_idle");

        bif.bus_data = 16'h1111; bif.ld_ac = 1; bif.clr_ac = 1;
        ex(1, S_AC, 32'h0000, "ac_clr_over_ld");
        ex(1, S_ERR, CONF, "err_ac_conflict");
        @(negedge CLK); clr_ctrl();
        repeat (3) @(negedge CLK);
        ex(0, S_ERR, CONF, "err_sticky");
        ex(0, S_AC, 32'h0000, "ac_hold_zero");

        repeat (2) @(negedge CLK);
        #5;
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("wr_queue_drained", wr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_load_bank.md
Name: bus_load_bank

Overview:
- Destination end of the common bus. It holds the AR, PC, DR, AC, IR and TR registers, which load, increment or clear from bus_data under control strobes.
- Register outputs feed back to buschooser as its source inputs.
- A memory-write handshake engine captures AR and bus_data and drives a single outstanding write to memory.

Parameters:
- ADDR_W, 12, width of AR, PC and mem_addr.
- DATA_W, 16, width of DR, AC, IR, TR, bus_data and mem_wdata.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- bus_data  input  DATA_W  common bus value.
- ld_ar, inr_ar, clr_ar  input  1 each  AR load / increment / clear.
- ld_pc, inr_pc, clr_pc  input  1 each  PC load / increment / clear.
- ld_dr, inr_dr, clr_dr  input  1 each  DR load / increment / clear.
- ld_ac, inr_ac, clr_ac  input  1 each  AC load / increment / clear.
- ld_ir  input  1  IR load.
- ld_tr, inr_tr, clr_tr  input  1 each  TR load / increment / clear.
- mem_wr_req  input  1  request to write bus_data to M[AR].
- mem_wr_ack  input  1  memory accepted the write.
- ar_outdata  output  ADDR_W  AR contents.
- pc_outdata  output  ADDR_W  PC contents.
- dr_outdata, ac_outdata, ir_outdata, tr_outdata  output  DATA_W each  register contents.
- mem_write  output  1  write strobe, held until acknowledged.
- mem_addr  output  ADDR_W  captured write address.
- mem_wdata  output  DATA_W  captured write data.
- wr_done  output  1  one-cycle pulse when a write completes.
- busy  output  1  write engine not IDLE.
- err_conflict  output  1  sticky control-conflict flag (optional feature).

Behaviour:
- Reset (RST high, asynchronous): all registers 0; mem_write, wr_done and busy 0; mem_addr and mem_wdata 0; err_conflict 0; FSM in IDLE. Asserting RST mid-write aborts the write immediately, and mem_write drops without waiting for CLK.
- Register updates occur on the CLK rising edge with 1-cycle latency; outputs are registered.
- Per-register priority is clr > ld > inr > hold.
- Registers are independent, so any combination of registers may update in the same cycle.
- AR/PC load takes bus_data[ADDR_W-1:0]. 16-bit registers load the full bus.
- Increment wraps modulo 2^width: AR 12'hFFF -> 12'h000; AC 16'hFFFF -> 16'h0000.
- IR has load only.
- Write FSM states IDLE, WAIT, DONE:
  - IDLE: when mem_wr_req is high, capture mem_addr <= AR value before this edge's update and mem_wdata <= bus_data; set mem_write=1 and busy=1; go to WAIT.
  - WAIT: hold mem_write, mem_addr and mem_wdata stable. When mem_wr_ack is high, set mem_write=0 and go to DONE. mem_wr_req is ignored in this state.
  - DONE: wr_done=1 for this cycle only, busy=1; go to IDLE unconditionally. A request arriving here is ignored and must be re-presented in IDLE.
  - mem_wr_ack outside WAIT is ignored.
  - mem_wr_ack in the same cycle mem_write is first asserted is not seen; ack is sampled from WAIT onward.
- Minimum write turnaround is 3 cycles: req -> WAIT -> DONE -> IDLE.
- A register load and a write capture in the same cycle are both performed.

Optional Feature:
- Macro BUS_CONFLICT_CHECK_EN.
- When defined:
  - err_conflict is set on any edge where more than one of ld/inr/clr is high for the same register.
  - It is also set when mem_wr_req is high while busy=1.
  - The flag is sticky until RST.
  - Priority resolution is unchanged.
- When undefined: err_conflict is tied to 0 and no checker logic is synthesized.

Test Plan:
- Reset then idle -> all six register outputs 0, mem_write 0, busy 0.
- bus_data=16'hA123 with ld_ar=1 and ld_ac=1 for one cycle -> ar_outdata=12'h123, ac_outdata=16'hA123 after one edge. Then inr_ar=1 x2 -> 12'h125.
- Load PC with 16'h0FFF, then inr_pc -> 12'h000. Load TR with 16'hFFFF, then inr_tr -> 16'h0000. clr_dr, ld_dr and inr_dr together on 16'h0042 -> DR=0.
- AR=12'h010, bus_data=16'h5555, mem_wr_req pulse; ack delayed 4 cycles -> mem_write high 5 cycles with mem_addr 12'h010 and mem_wdata 16'h5555 stable; wr_done pulses once the cycle after ack; busy returns to 0.
- Assert RST while in WAIT -> mem_write and busy fall asynchronously, registers 0. A later ack causes no wr_done.
- With BUS_CONFLICT_CHECK_EN: ld_ac and clr_ac together -> err_conflict=1 and stays 1. Second mem_wr_req during WAIT -> flag set and no second write issued.
